// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_mem_arbiter_pkg : state and side encodings shared by the memory arbiter
// Revision : 1.0
// ----------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

  localparam int LINE_OFFSET_BITS = 2;

  function automatic side_e other_side(input side_e s);
    return (s == SIDE_D) ? SIDE_I : SIDE_D;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_latency_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_latency_timer : counts the cycles of a fixed-latency memory access
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_latency_timer #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = $clog2(MEM_LATENCY) + 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic run_i,
  output logic last_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o = run_i && (cnt_q == CNT_W'(MEM_LATENCY - 1));

  // Saturates at the last count so a stuck run_i can never wrap the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cache_mem_arbiter : round-robin sharing of one fixed-latency memory port
//                     between the I-cache and D-cache
// Revision : 1.0
// ----------------------------------------------------------------------------
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int FETCH_SIZE  = 64,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [WORD_SIZE-1:0]  i_addr,
  output logic                  i_ack,
  output logic [FETCH_SIZE-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [WORD_SIZE-1:0]  d_addr,
  input  logic [WORD_SIZE-1:0]  d_wdata,
  output logic                  d_ack,
  output logic [FETCH_SIZE-1:0] d_rdata,
  output logic                  m_read,
  output logic                  m_write,
  output logic [WORD_SIZE-1:0]  m_address,
  output logic [WORD_SIZE-1:0]  m_wdata,
  input  logic [FETCH_SIZE-1:0] m_rdata,
  output logic                  busy
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);

  logic [1:0]            state_q, state_d;
  side_e                 rr_q, rr_d;
  side_e                 side_q, side_d;
  side_e                 w_pick;
  logic                  we_q, we_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic [FETCH_SIZE-1:0] i_rdata_q, d_rdata_q;
  logic                  w_in_busy;
  logic                  w_last;

  assign w_in_busy = (state_q == ARB_BUSY);

  mem_latency_timer #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (!w_in_busy),
    .run_i   (w_in_busy),
    .last_o  (w_last)
  );

  // A tie goes to rr_q; a lone requester wins without touching rr_q.
  always_comb begin
    if (i_req && d_req) begin
      w_pick = rr_q;
    end else if (d_req) begin
      w_pick = SIDE_D;
    end else begin
      w_pick = SIDE_I;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    side_d  = side_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            rr_d = other_side(rr_q);
          end
          side_d  = w_pick;
          we_d    = (w_pick == SIDE_D) && d_we;
          addr_d  = (w_pick == SIDE_D) ? d_addr : i_addr;
          wdata_d = ((w_pick == SIDE_D) && d_we) ? d_wdata : '0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (w_last) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ARB_IDLE;
      rr_q      <= SIDE_D;
      side_q    <= SIDE_D;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      side_q  <= side_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (w_last && !we_q) begin
        if (side_q == SIDE_I) begin
          i_rdata_q <= m_rdata;
        end else begin
          d_rdata_q <= m_rdata;
        end
      end
    end
  end

  assign m_read    = w_in_busy && !we_q;
  assign m_write   = w_in_busy && we_q;
  assign m_address = !w_in_busy ? '0 :
                     we_q       ? addr_q :
                                  {addr_q[WORD_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign m_wdata   = m_write ? wdata_q : '0;
  assign i_ack     = (state_q == ARB_DONE) && (side_q == SIDE_I);
  assign d_ack     = (state_q == ARB_DONE) && (side_q == SIDE_D);
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cache_mem_arbiter : scoreboard bench with a transaction-level arbiter model
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

  localparam int LAT = 4;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [63:0] line;
  } req_t;

  logic        clk;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, m_read, m_write, busy;
  logic [63:0] i_rdata, d_rdata, m_rdata;
  logic [15:0] m_address, m_wdata;

  req_t qi[$];
  req_t qd[$];
  bit   grant_log[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // transaction model state
  bit   act = 0;
  bit   m_d = 0;
  req_t m_r;
  int   t_start = 0, t_ack = 0, free_at = 0;
  bit   rr_next_d = 1;

  cache_mem_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] line_of(input logic [15:0] a);
    return {a ^ 16'hA5C3, ~a, a + 16'h1357, a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Memory: line only valid in the final strobe cycle, junk otherwise.
  initial begin : g_mem
    int mcnt;
    mcnt    = 0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (m_read) begin
        mcnt++;
        m_rdata = (mcnt == LAT) ? line_of(m_address) : {$urandom, $urandom};
      end else begin
        mcnt    = 0;
        m_rdata = {$urandom, $urandom};
      end
    end
  end

  always @(negedge clk) begin : g_monitor
    bit          strobe;
    logic [4:0]  exp_ctl;
    logic [15:0] exp_addr, exp_wdata;
    req_t        e;
    cyc++;
    if (!reset_n) begin
      act       = 0;
      free_at   = 0;
      rr_next_d = 1;
      qi.delete();
      qd.delete();
    end else begin
      strobe    = act && (cyc >= t_start) && (cyc < t_start + LAT);
      exp_ctl   = {act, strobe && !m_r.we, strobe && m_r.we,
                   act && (cyc == t_ack) && !m_d, act && (cyc == t_ack) && m_d};
      exp_addr  = !strobe ? 16'h0 : (m_r.we ? m_r.addr : (m_r.addr & 16'hFFFC));
      exp_wdata = (strobe && m_r.we) ? m_r.wdata : 16'h0;
      chk("ctl{busy,rd,wr,iack,dack}", {59'd0, busy, m_read, m_write, i_ack, d_ack}, {59'd0, exp_ctl});
      chk("m_address", {48'd0, m_address}, {48'd0, exp_addr});
      chk("m_wdata", {48'd0, m_wdata}, {48'd0, exp_wdata});
      if (i_ack) begin
        grant_log.push_back(1'b0);
        if (qi.size() == 0) chk("i_ack_unexpected", 64'd1, 64'd0);
        else begin
          e = qi.pop_front();
          chk("i_rdata", i_rdata, e.line);
        end
      end
      if (d_ack) begin
        grant_log.push_back(1'b1);
        if (qd.size() == 0) chk("d_ack_unexpected", 64'd1, 64'd0);
        else begin
          e = qd.pop_front();
          if (!e.we) chk("d_rdata", d_rdata, e.line);
        end
      end
      if (act && cyc == t_ack) begin
        act     = 0;
        free_at = cyc + 1;
      end
      if (!act && cyc >= free_at && (i_req || d_req)) begin
        m_d = (i_req && d_req) ? rr_next_d : d_req;
        if (i_req && d_req) rr_next_d = !rr_next_d;
        if ((m_d && qd.size() == 0) || (!m_d && qi.size() == 0)) begin
          chk("req_without_entry", 64'd1, 64'd0);
          m_r = '{we: 1'b0, addr: 16'h0, wdata: 16'h0, line: 64'h0};
        end else begin
          m_r = m_d ? qd[0] : qi[0];
        end
        act     = 1;
        t_start = cyc + 1;
        t_ack   = cyc + 1 + LAT;
      end
    end
  end

  // Entered and left just after a rising edge.
  task automatic do_req(input bit is_d, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input int gap);
    req_t e;
    int   n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    e.we    = is_d && we;
    e.addr  = addr;
    e.wdata = (is_d && we) ? wdata : 16'h0;
    e.line  = line_of(addr & 16'hFFFC);
    if (is_d) begin
      d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      qd.push_back(e);
    end else begin
      i_addr = addr; i_req = 1'b1;
      qi.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_ack : i_ack) && n < 60);
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL ack_timeout side=%0d: got no ack expected ack within 60 cycles", is_d);
    end
    @(posedge clk);
    #1;
    if (is_d) d_req = 1'b0;
    else      i_req = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    i_req   = 1'b0;
    d_req   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic logic [63:0] pack_log(input int len);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < len; k++) begin
      v = {v[62:0], (k < grant_log.size()) ? grant_log[k] : 1'b0};
    end
    return v;
  endfunction

  initial begin : g_main
    req_t e;
    reset_n = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_ctl", {59'd0, busy, m_read, m_write, i_ack, d_ack}, 64'd0);
    chk("reset_addr_data", {32'd0, m_address, m_wdata}, 64'd0);
    chk("reset_i_rdata", i_rdata, 64'd0);
    chk("reset_d_rdata", d_rdata, 64'd0);
    @(posedge clk);
    #1;

    // I-only fill, then D write-through
    do_req(1'b0, 1'b0, 16'h0013, 16'h0, 0);
    do_req(1'b1, 1'b1, 16'h0081, 16'hBEEF, 1);

    // Contention straight after reset: D first
    do_reset();
    grant_log.delete();
    fork
      do_req(1'b1, 1'b0, 16'h1234, 16'h0, 0);
      do_req(1'b0, 1'b0, 16'h5678, 16'h0, 0);
    join
    chk("contention_order", {62'd0, grant_log.size() == 2, 1'b0} | pack_log(2), 64'd2 | 64'd2);
    chk("contention_first_is_d", pack_log(2), 64'b10);

    // Sustained contention: D,I,D,I,D,I
    do_reset();
    grant_log.delete();
    fork
      repeat (3) do_req(1'b1, 1'($urandom), 16'($urandom), 16'($urandom), 0);
      repeat (3) do_req(1'b0, 1'b0, 16'($urandom), 16'h0, 0);
    join
    chk("sustained_len", 64'(grant_log.size()), 64'd6);
    chk("sustained_order", pack_log(6), 64'b101010);

    // Reset in the 2nd BUSY cycle of a D fill
    do_reset();
    e = '{we: 1'b0, addr: 16'h0300, wdata: 16'h0, line: line_of(16'h0300)};
    d_we = 1'b0; d_addr = 16'h0300; d_req = 1'b1;
    qd.push_back(e);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    d_req   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("mid_busy_reset_ctl", {59'd0, busy, m_read, m_write, i_ack, d_ack}, 64'd0);
    chk("mid_busy_reset_d_rdata", d_rdata, 64'd0);
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      do_req(1'b1, 1'b0, 16'h0404, 16'h0, 0);
      do_req(1'b0, 1'b0, 16'h0808, 16'h0, 1);
    join
    chk("after_reset_order", pack_log(2), 64'b10);

    // Back-to-back I fills
    do_req(1'b0, 1'b0, 16'h0040, 16'h0, 0);
    do_req(1'b0, 1'b0, 16'h0044, 16'h0, 0);
    chk("b2b_i_rdata", i_rdata, line_of(16'h0044));

    // Random traffic from both sides
    fork
      repeat (20) do_req(1'b0, 1'b0, 16'($urandom), 16'h0, int'($urandom_range(0, 3)));
      repeat (20) do_req(1'b1, 1'($urandom), 16'($urandom), 16'($urandom),
                         int'($urandom_range(0, 3)));
    join

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : g_watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
